// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and FSM state type for the multi-precision adder/subtractor.
//   OP_W      : operand width in bits
//   RES_W     : result width, one bit wider than the operands
//   LIMB_W    : bits processed per cycle
//   NUM_LIMBS : limbs needed to cover RES_W bits (zero-padded)
//   INT_W     : internal register width, NUM_LIMBS * LIMB_W
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int unsigned OP_W      = 514;
    localparam int unsigned RES_W     = OP_W + 1;
    localparam int unsigned LIMB_W    = 128;
    localparam int unsigned NUM_LIMBS = 5;
    localparam int unsigned INT_W     = NUM_LIMBS * LIMB_W;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : adder_pkg

// File: rtl/adder_limb_adder.sv
// -----------------------------------------------------------------------------
// limb_adder
// W-bit ripple adder with carry-in and carry-out; one limb of the wide adder.
// Ports:
//   i_a, i_b  : W-bit addends
//   i_carry   : carry-in
//   o_sum     : low W bits of i_a + i_b + i_carry
//   o_carry   : carry-out
// -----------------------------------------------------------------------------
module limb_adder #(
    parameter int unsigned W = 128
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_carry,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);

    logic [W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_carry};
    assign o_sum   = w_full[W-1:0];
    assign o_carry = w_full[W];

endmodule : limb_adder

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// Multi-cycle 514-bit adder/subtractor. Operands are captured on start and
// summed one 128-bit limb per cycle with a registered carry; done rises on the
// fifth clock edge after start and holds until the next start.
// Ports:
//   clk      : rising-edge clock
//   resetn   : asynchronous active-low reset
//   start    : one-cycle pulse; captures in_a, in_b, subtract and (re)starts
//   subtract : 0 = a+b, 1 = a-b (sampled with start)
//   shift    : live select; 1 = result presented shifted right by one bit
//   in_a     : operand A (OP_W bits)
//   in_b     : operand B (OP_W bits)
//   result   : RES_W-bit sum/difference, or its logical right shift by one
//   done     : high while result is valid
// -----------------------------------------------------------------------------
module adder
    import adder_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              subtract,
    input  logic              shift,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [RES_W-1:0]  result,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

    state_t            r_state;
    logic [INT_W-1:0]  r_a;
    logic [INT_W-1:0]  r_b;
    logic [INT_W-1:0]  r_sum;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic              r_done;

    logic [INT_W-1:0]  w_a_ext;
    logic [INT_W-1:0]  w_b_ext;
    logic [LIMB_W-1:0] w_limb_sum;
    logic              w_limb_carry;

    // Subtraction is a + ~b + 1 over RES_W bits; the +1 enters as the initial
    // carry. Inverting only the low RES_W bits keeps the padding limb clean.
    always_comb begin
        w_a_ext = INT_W'(in_a);
        w_b_ext = INT_W'(in_b);
        if (subtract) begin
            w_b_ext[RES_W-1:0] = ~w_b_ext[RES_W-1:0];
        end
    end

    // Operands shift down one limb per cycle so the adder always sees limb 0;
    // each new sum limb enters at the top of r_sum and, after NUM_LIMBS
    // shifts, limb 0 has arrived at the bottom.
    limb_adder #(
        .W (LIMB_W)
    ) u_limb_adder (
        .i_a     (r_a[LIMB_W-1:0]),
        .i_b     (r_b[LIMB_W-1:0]),
        .i_carry (r_carry),
        .o_sum   (w_limb_sum),
        .o_carry (w_limb_carry)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_state <= RUN;
            r_a     <= w_a_ext;
            r_b     <= w_b_ext;
            r_carry <= subtract;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_a     <= r_a >> LIMB_W;
                    r_b     <= r_b >> LIMB_W;
                    r_sum   <= {w_limb_sum, r_sum[INT_W-1:LIMB_W]};
                    r_carry <= w_limb_carry;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = shift ? {1'b0, r_sum[RES_W-1:1]} : r_sum[RES_W-1:0];
    assign done   = r_done;

endmodule : adder

// File: tb/tb_adder.sv
module tb_adder;
    import adder_pkg::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              subtract;
    logic              shift;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic [RES_W-1:0]  result;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [RES_W-1:0] sb_q[$];

    adder dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .shift    (shift),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] model(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b,
                                                input logic sub);
        logic [RES_W-1:0] ea;
        logic [RES_W-1:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return sub ? (ea - eb) : (ea + eb);
    endfunction

    task automatic chk(input string tag, input logic [RES_W-1:0] obs,
                       input logic [RES_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse sampled by exactly one rising edge; push the model result.
    task automatic do_start(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                            input logic sub);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        subtract = sub;
        start    = 1'b1;
        sb_q.push_back(model(a, b, sub));
        @(negedge clk);
        start    = 1'b0;
        in_a     = '0;
        in_b     = '0;
        subtract = 1'b0;
    endtask

    // Count cycles until done, bounded; the latency itself is checked.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, RES_W'(lat), RES_W'(5));
    endtask

    task automatic chk_pop(input string tag);
        logic [RES_W-1:0] exp;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, result, exp);
        end
    endtask

    task automatic op(input string tag, input logic [OP_W-1:0] a,
                      input logic [OP_W-1:0] b, input logic sub);
        do_start(a, b, sub);
        wait_done(tag);
        chk_pop(tag);
    endtask

    initial begin
        logic [OP_W-1:0]  ones;
        logic [OP_W-1:0]  v;
        logic [RES_W-1:0] half_max;
        ones     = '1;
        half_max = {1'b0, ones};

        resetn = 1'b0; start = 1'b0; subtract = 1'b0; shift = 1'b0;
        in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_done", RES_W'(done), RES_W'(0));
        chk("reset_result", result, '0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_done", RES_W'(done), RES_W'(0));

        // 1+1, then done and result hold while idle
        op("add_1_1", OP_W'(1), OP_W'(1), 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_done", RES_W'(done), RES_W'(1));
        chk("hold_result", result, RES_W'(2));

        // max + max, with shift toggling
        op("add_max", ones, ones, 1'b0);
        shift = 1'b1;
        #1 chk("add_max_shift1", result, half_max);
        shift = 1'b0;
        #1 chk("add_max_shift0", result, {ones, 1'b0});
        shift = 1'b1;
        #1 chk("add_max_shift1_again", result, half_max);
        shift = 1'b0;

        // carries across limb boundaries
        v = (OP_W'(1) << 128) - OP_W'(1);
        op("carry_128", v, OP_W'(1), 1'b0);
        v = (OP_W'(1) << 512) - OP_W'(1);
        op("carry_512", v, OP_W'(1) << 512, 1'b0);
        v = (OP_W'(1) << 384) - OP_W'(1);
        op("carry_384", v, v, 1'b0);

        // subtraction
        op("sub_1_1", OP_W'(1), OP_W'(1), 1'b1);
        op("sub_0_1", OP_W'(0), OP_W'(1), 1'b1);
        shift = 1'b1;
        #1 chk("sub_0_1_shift", result, half_max);
        shift = 1'b0;
        op("sub_5_3", OP_W'(5), OP_W'(3), 1'b1);
        op("sub_big", ones, (OP_W'(1) << 300), 1'b1);

        // restart during RUN: the first operation never completes
        do_start(OP_W'(7), OP_W'(8), 1'b0);
        @(negedge clk);
        chk("restart_run_done", RES_W'(done), RES_W'(0));
        void'(sb_q.pop_front());
        do_start(OP_W'(100), OP_W'(23), 1'b0);
        wait_done("restart");
        chk_pop("restart");

        // asynchronous reset mid-RUN
        do_start(ones, OP_W'(9), 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_done", RES_W'(done), RES_W'(0));
        chk("arst_result", result, '0);
        void'(sb_q.pop_front());
        @(negedge clk);
        resetn = 1'b1;
        op("after_reset_add", OP_W'(2), OP_W'(3), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder

// File: doc/adder.md
Name: adder

Overview:
- Multi-cycle, multi-precision 514-bit adder/subtractor for the RSA datapath; used by the Montgomery stages for add, subtract and halve steps.
- Operands are captured on `start`, then added limb by limb with a registered carry.
- Produces a 515-bit result and a level `done` flag.
- Optionally presents the result shifted right by one bit, for divide-by-2.

Parameters:
- OP_W, 514, operand width in bits.
- LIMB_W, 128, bits processed per cycle. Internal width is 640, i.e. 5 limbs covering OP_W+1 bits zero-padded.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; captures operands and mode, then begins an operation.
- subtract  in  1  sampled with start; 0 = a+b, 1 = a-b.
- shift  in  1  live (unregistered) output select; 1 = result shown shifted right by 1.
- in_a  in  514  operand A, sampled with start.
- in_b  in  514  operand B, sampled with start.
- result  out  515  sum/difference, or its 1-bit right shift.
- done  out  1  high when result is valid; held until the next start.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State goes to IDLE; done=0; the internal sum register and carry are cleared; result=0.
  - Reset mid-operation aborts immediately; no partial result remains.
- States: IDLE, RUN, DONE.
- start=1 in any state, including RUN or DONE, on a rising edge:
  - Load A = {0, in_a} into a 640-bit register (zero-extended).
  - Load B = {0, in_b} into a 640-bit register (zero-extended); if subtract=1, store the bitwise inverse over the low 515 bits.
  - Set carry = subtract.
  - Clear done; set limb index 0; go to RUN.
- RUN, each cycle:
  - limb[i] = A[i] + B[i] + carry.
  - Store the low LIMB_W bits into sum limb i; carry = carry-out; i++.
  - After limb 4 go to DONE and set done=1.
- Latency:
  - done rises on the 5th rising edge after the edge that sampled start.
  - result is valid in the same cycle done is high.
- DONE:
  - done and the sum register hold indefinitely until the next start or reset.
  - in_a, in_b and subtract changes are ignored.
- Arithmetic:
  - Full sum S = sum register bits [514:0], computed mod 2^515.
  - Addition: S = a + b; the carry out of bit 513 lands in bit 514.
  - Subtraction: S = (a - b) mod 2^515, two's complement. a<b gives bit 514 = 1, e.g. 0-1 = all 515 bits set.
  - Bits above 514 are discarded.
- Output (combinational from the sum register and shift):
  - shift=0: result = S.
  - shift=1: result = {1'b0, S[514:1]}, a logical shift right.
  - shift never modifies stored state; toggling it repeatedly is idempotent.
- During RUN, result shows the partially updated register; consumers use it only when done=1.
- start held high for several cycles restarts each cycle. done appears 5 cycles after the last start.

Decomposition:
- Shared package holds:
  - OP_W = 514.
  - RES_W = OP_W + 1 = 515.
  - LIMB_W = 128.
  - NUM_LIMBS = 5.
  - The state enum (IDLE, RUN, DONE).
- One natural sub-module, `limb_adder`: a LIMB_W-bit adder with carry-in and carry-out. The top level holds the operand/sum shift registers, carry flop, counter and FSM.

Test Plan:
- Add 1+1, shift=0: done after 5 cycles; result = 0x2; done stays high while idle.
- Add a=b=2^514-1:
  - shift=0: result = 2^515-2.
  - shift=1 (after done): result = 2^514-1.
  - Toggle shift back to 0: result = 2^515-2 again.
- Carry across limb boundary, a=2^128-1, b=1: result = 2^128. Also a=2^512-1, b=2^512 gives 2^513-1.
- Subtract:
  - 1-1 gives 0x0.
  - 0-1 gives 515'h7FF…F (all ones).
  - 5-3 gives 0x2.
  - Under shift=1, the 0-1 result reads 2^514-1.
- Restart: start a second operation while the first is in RUN. done stays 0 until 5 cycles after the second start; result equals the second operation only.
- Reset mid-RUN: assert resetn=0 asynchronously (between edges). Immediately done=0 and result=0; after release, a new add 2+3 returns 0x5.
